core_mul_div_issue: RTL

Issue/writeback sequencer wrapped around the multicycle multiply/divide unit in the execute stage. Accepts M-extension operations from decode over a valid/ready handshake and holds operands and control stable for the whole operation. Drives the unit's enable and waits for its done pulse. Captures result and flags into a writeback register, presented to the register-file arbiter with backpressure and pipeline flush.

---
 rtl/core_mul_div_issue.sv | 235 +++++++++++++++++++++++
 1 files changed

// File: rtl/core_mul_div_issue.sv
// core_mul_div_issue: issue/writeback sequencer for the multicycle mul/div unit.
// Holds the operation stable while the unit runs, waits for its done pulse,
// and presents the result to the register-file arbiter with backpressure.
// Optional feature macro: MUL_DIV_ISSUE_SKID_EN adds a second (pending) entry
// so a new op can be accepted while the previous one executes or awaits writeback.
//
// Handshakes: a transfer happens on a rising clock edge where valid and ready are
// both high; valid never waits on ready, and a held valid keeps its payload stable.
module core_mul_div_issue #(
    parameter int XLEN  = 64,
    parameter int TAG_W = 5
) (
    input  logic             i_mul_div_issue_clk,
    input  logic             i_mul_div_issue_rst,
    input  logic             i_mul_div_issue_flush,
    input  logic             i_mul_div_issue_valid,
    output logic             o_mul_div_issue_ready,
    input  logic [XLEN-1:0]  i_mul_div_issue_srcA,
    input  logic [XLEN-1:0]  i_mul_div_issue_srcB,
    input  logic [2:0]       i_mul_div_issue_control,
    input  logic             i_mul_div_issue_isword,
    input  logic [TAG_W-1:0] i_mul_div_issue_rd,
    output logic [XLEN-1:0]  o_mul_div_issue_md_srcA,
    output logic [XLEN-1:0]  o_mul_div_issue_md_srcB,
    output logic [2:0]       o_mul_div_issue_md_control,
    output logic             o_mul_div_issue_md_isword,
    output logic             o_mul_div_issue_md_en,
    input  logic             i_mul_div_issue_md_busy,
    input  logic             i_mul_div_issue_md_done,
    input  logic [XLEN-1:0]  i_mul_div_issue_md_result,
    input  logic             i_mul_div_issue_md_overflow,
    input  logic             i_mul_div_issue_md_div_by_zero,
    output logic             o_mul_div_issue_wb_valid,
    input  logic             i_mul_div_issue_wb_ready,
    output logic [XLEN-1:0]  o_mul_div_issue_wb_data,
    output logic [TAG_W-1:0] o_mul_div_issue_wb_rd,
    output logic [1:0]       o_mul_div_issue_wb_flags,
    output logic             o_mul_div_issue_busy,
    output logic [1:0]       o_mul_div_issue_state
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_HOLD  = 2'd3;

    typedef struct packed {
        logic [XLEN-1:0]  src_a;
        logic [XLEN-1:0]  src_b;
        logic [2:0]       control;
        logic             isword;
        logic [TAG_W-1:0] rd;
    } entry_t;

    logic [1:0]       state_q, state_d;
    logic             kill_q, kill_d;
    logic             head_valid_q, head_valid_d;
    entry_t           head_q, head_d;
    logic [XLEN-1:0]  wb_data_q, wb_data_d;
    logic [TAG_W-1:0] wb_rd_q, wb_rd_d;
    logic [1:0]       wb_flags_q, wb_flags_d;

    entry_t req;
    logic   accept;
    logic   in_exec;
    logic   done_ev;
    logic   capture;
    logic   unused_md_busy;

    // The unit's busy flag is redundant with our own state tracking.
    assign unused_md_busy = i_mul_div_issue_md_busy;

    assign req = '{src_a:   i_mul_div_issue_srcA,
                   src_b:   i_mul_div_issue_srcB,
                   control: i_mul_div_issue_control,
                   isword:  i_mul_div_issue_isword,
                   rd:      i_mul_div_issue_rd};

    assign accept  = i_mul_div_issue_valid & o_mul_div_issue_ready;
    assign in_exec = (state_q == ST_START) || (state_q == ST_WAIT);
    // done is only meaningful while an op is in the unit
    assign done_ev = in_exec & i_mul_div_issue_md_done;
    // a killed op finishes in the unit but its result is thrown away
    assign capture = done_ev & ~kill_q & ~i_mul_div_issue_flush;

`ifdef MUL_DIV_ISSUE_SKID_EN
    logic   pend_valid_q, pend_valid_d;
    entry_t pend_q, pend_d;

    assign o_mul_div_issue_ready = ~i_mul_div_issue_rst & ~i_mul_div_issue_flush &
                                   ~(head_valid_q & pend_valid_q);
    assign o_mul_div_issue_busy  = (state_q != ST_IDLE) | head_valid_q | pend_valid_q;

    // Two-entry queue: head stays put until the unit finishes, then pending shifts up.
    always_comb begin
        head_valid_d = head_valid_q;
        head_d       = head_q;
        pend_valid_d = pend_valid_q;
        pend_d       = pend_q;
        if (i_mul_div_issue_flush) begin
            pend_valid_d = 1'b0;
            // an in-flight head must keep driving the unit until done arrives
            if (!in_exec || done_ev) begin
                head_valid_d = 1'b0;
            end
        end else begin
            if (done_ev) begin
                head_valid_d = pend_valid_q;
                if (pend_valid_q) begin
                    head_d = pend_q;
                end
                pend_valid_d = 1'b0;
            end
            if (accept) begin
                if (!head_valid_d) begin
                    head_valid_d = 1'b1;
                    head_d       = req;
                end else begin
                    pend_valid_d = 1'b1;
                    pend_d       = req;
                end
            end
        end
    end

    // Pending entry storage.
    always_ff @(posedge i_mul_div_issue_clk) begin
        if (i_mul_div_issue_rst) begin
            pend_valid_q <= 1'b0;
            pend_q       <= '0;
        end else begin
            pend_valid_q <= pend_valid_d;
            pend_q       <= pend_d;
        end
    end
`else
    assign o_mul_div_issue_ready = ~i_mul_div_issue_rst & ~i_mul_div_issue_flush &
                                   (state_q == ST_IDLE) & ~head_valid_q;
    assign o_mul_div_issue_busy  = (state_q != ST_IDLE) | head_valid_q;

    // Single entry: loaded on accept, released when the unit finishes.
    always_comb begin
        head_valid_d = head_valid_q;
        head_d       = head_q;
        if (i_mul_div_issue_flush) begin
            if (!in_exec || done_ev) begin
                head_valid_d = 1'b0;
            end
        end else begin
            if (done_ev) begin
                head_valid_d = 1'b0;
            end
            if (accept) begin
                head_valid_d = 1'b1;
                head_d       = req;
            end
        end
    end
`endif

    // Sequencer FSM plus writeback register capture.
    always_comb begin
        state_d    = state_q;
        kill_d     = kill_q;
        wb_data_d  = wb_data_q;
        wb_rd_d    = wb_rd_q;
        wb_flags_d = wb_flags_q;
        case (state_q)
            ST_IDLE: begin
                // accepting straight into START gives md_en the cycle after accept
                if (!i_mul_div_issue_flush && (accept || head_valid_q)) begin
                    state_d = ST_START;
                end
            end
            ST_START, ST_WAIT: begin
                if (i_mul_div_issue_md_done) begin
                    kill_d  = 1'b0;
                    state_d = (kill_q || i_mul_div_issue_flush) ? ST_IDLE : ST_HOLD;
                    if (capture) begin
                        wb_data_d  = i_mul_div_issue_md_result;
                        wb_rd_d    = head_q.rd;
                        wb_flags_d = {i_mul_div_issue_md_overflow,
                                      i_mul_div_issue_md_div_by_zero};
                    end
                end else begin
                    if (i_mul_div_issue_flush) begin
                        kill_d = 1'b1;
                    end
                    state_d = ST_WAIT;
                end
            end
            ST_HOLD: begin
                if (i_mul_div_issue_flush) begin
                    state_d = ST_IDLE;
                end else if (i_mul_div_issue_wb_ready) begin
                    state_d = head_valid_q ? ST_START : ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, head entry and writeback registers.
    always_ff @(posedge i_mul_div_issue_clk) begin
        if (i_mul_div_issue_rst) begin
            state_q      <= ST_IDLE;
            kill_q       <= 1'b0;
            head_valid_q <= 1'b0;
            head_q       <= '0;
            wb_data_q    <= '0;
            wb_rd_q      <= '0;
            wb_flags_q   <= '0;
        end else begin
            state_q      <= state_d;
            kill_q       <= kill_d;
            head_valid_q <= head_valid_d;
            head_q       <= head_d;
            wb_data_q    <= wb_data_d;
            wb_rd_q      <= wb_rd_d;
            wb_flags_q   <= wb_flags_d;
        end
    end

    assign o_mul_div_issue_md_srcA    = head_q.src_a;
    assign o_mul_div_issue_md_srcB    = head_q.src_b;
    assign o_mul_div_issue_md_control = head_q.control;
    assign o_mul_div_issue_md_isword  = head_q.isword;
    assign o_mul_div_issue_md_en      = (state_q == ST_START);
    assign o_mul_div_issue_wb_valid   = (state_q == ST_HOLD);
    assign o_mul_div_issue_wb_data    = wb_data_q;
    assign o_mul_div_issue_wb_rd      = wb_rd_q;
    assign o_mul_div_issue_wb_flags   = wb_flags_q;
    assign o_mul_div_issue_state      = state_q;

endmodule
